// File: rtl/memwb_reg_if.sv
// MEM->WB boundary bundle: pipeline controls, MEM-stage fields, memory response, WB outputs.
// Latency: none; this is wiring only.
// Backpressure: stall_mem/stall_wb/flush from the hazard unit; mem_data_ok releases the MEM stall.
interface memwb_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Pipeline control
  logic                  stall_mem;
  logic                  stall_wb;
  logic                  flush;

  // MEM-stage instruction fields
  logic [REG_AW-1:0]     mem_wa;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_dreg;
  logic                  mem_mreg;
  logic [3:0]            mem_dre;
  logic                  mem_sign;
  logic                  mem_whilo;
  logic [2*DATA_W-1:0]   mem_hilo;
  logic                  mem_cp0_we;
  logic [REG_AW-1:0]     mem_cp0_waddr;
  logic [DATA_W-1:0]     mem_cp0_wdata;

  // Data-memory response
  logic                  data_ok;
  logic [DATA_W-1:0]     data_rdata;
  logic                  mem_data_ok;

  // Write-back stage fields
  logic [REG_AW-1:0]     wb_wa;
  logic                  wb_wreg;
  logic [DATA_W-1:0]     wb_wd;
  logic                  wb_whilo;
  logic [2*DATA_W-1:0]   wb_hilo;
  logic                  wb_cp0_we;
  logic [REG_AW-1:0]     wb_cp0_waddr;
  logic [DATA_W-1:0]     wb_cp0_wdata;

  // Driver side: pipeline and memory feed the register
  modport master (
    output stall_mem, stall_wb, flush,
    output mem_wa, mem_wreg, mem_dreg, mem_mreg, mem_dre, mem_sign,
    output mem_whilo, mem_hilo, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
    output data_ok, data_rdata,
    input  mem_data_ok,
    input  wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo,
    input  wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata
  );

  // Register side
  modport slave (
    input  stall_mem, stall_wb, flush,
    input  mem_wa, mem_wreg, mem_dreg, mem_mreg, mem_dre, mem_sign,
    input  mem_whilo, mem_hilo, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
    input  data_ok, data_rdata,
    output mem_data_ok,
    output wb_wa, wb_wreg, wb_wd, wb_whilo, wb_hilo,
    output wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata
  );
endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: holds the data-memory read response, extracts/extends the load, registers WB controls.
// Latency: 1 cycle MEM->WB; mem_data_ok rises the cycle after data_ok. Optional macro LOAD_BYTE_SWAP_EN.
// Backpressure: flush > bubble (stall_mem & !stall_wb) > advance (!stall_mem) > hold.
module memwb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           cpu_clk_50M,
  input  logic           cpu_rst_n,
  memwb_reg_if.slave     bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0]          state_q,        state_d;
  logic [DATA_W-1:0]   hold_q,         hold_d;
  logic [REG_AW-1:0]   wb_wa_q,        wb_wa_d;
  logic                wb_wreg_q,      wb_wreg_d;
  logic [DATA_W-1:0]   wb_wd_q,        wb_wd_d;
  logic                wb_whilo_q,     wb_whilo_d;
  logic [2*DATA_W-1:0] wb_hilo_q,      wb_hilo_d;
  logic                wb_cp0_we_q,    wb_cp0_we_d;
  logic [REG_AW-1:0]   wb_cp0_waddr_q, wb_cp0_waddr_d;
  logic [DATA_W-1:0]   wb_cp0_wdata_q, wb_cp0_wdata_d;

  // Byte-swapped storage applies only to the local region (kseg/low memory and boot ROM).
  logic swap_en;
`ifdef LOAD_BYTE_SWAP_EN
  assign swap_en = (bus.mem_dreg[31:28] == 4'h8) ||
                   (bus.mem_dreg[31:28] == 4'h0) ||
                   (bus.mem_dreg[31:20] == 12'hbfc);
`else
  assign swap_en = 1'b0;
`endif

  // Lane extraction and extension of the held read word
  logic [DATA_W-1:0] load_wd;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              is_byte;
  logic              is_half;

  always_comb begin
    load_wd = '0;
    byte_v  = 8'h00;
    half_v  = 16'h0000;
    is_byte = 1'b0;
    is_half = 1'b0;
    case (bus.mem_dre)
      4'b1000: begin byte_v = hold_q[31:24]; is_byte = 1'b1; end
      4'b0100: begin byte_v = hold_q[23:16]; is_byte = 1'b1; end
      4'b0010: begin byte_v = hold_q[15:8];  is_byte = 1'b1; end
      4'b0001: begin byte_v = hold_q[7:0];   is_byte = 1'b1; end
      4'b1100: begin
        half_v  = swap_en ? {hold_q[23:16], hold_q[31:24]} : hold_q[31:16];
        is_half = 1'b1;
      end
      4'b0011: begin
        half_v  = swap_en ? {hold_q[7:0], hold_q[15:8]} : hold_q[15:0];
        is_half = 1'b1;
      end
      4'b1111: begin
        load_wd = swap_en ? {hold_q[7:0], hold_q[15:8], hold_q[23:16], hold_q[31:24]}
                          : hold_q;
      end
      default: load_wd = '0;
    endcase
    if (is_byte) begin
      load_wd = {{(DATA_W-8){bus.mem_sign & byte_v[7]}}, byte_v};
    end else if (is_half) begin
      load_wd = {{(DATA_W-16){bus.mem_sign & half_v[15]}}, half_v};
    end
  end

  // Next-state: response capture, then flush > bubble > advance > hold
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    wb_wa_d        = wb_wa_q;
    wb_wreg_d      = wb_wreg_q;
    wb_wd_d        = wb_wd_q;
    wb_whilo_d     = wb_whilo_q;
    wb_hilo_d      = wb_hilo_q;
    wb_cp0_we_d    = wb_cp0_we_q;
    wb_cp0_waddr_d = wb_cp0_waddr_q;
    wb_cp0_wdata_d = wb_cp0_wdata_q;

    // A second data_ok while HELD is a protocol violation; the first response wins.
    if (state_q == IDLE && bus.data_ok) begin
      hold_d  = bus.data_rdata;
      state_d = HELD;
    end

    if (bus.flush) begin
      state_d        = IDLE;
      wb_wa_d        = '0;
      wb_wreg_d      = 1'b0;
      wb_wd_d        = '0;
      wb_whilo_d     = 1'b0;
      wb_hilo_d      = '0;
      wb_cp0_we_d    = 1'b0;
      wb_cp0_waddr_d = '0;
      wb_cp0_wdata_d = '0;
    end else if (bus.stall_mem && !bus.stall_wb) begin
      wb_wa_d        = '0;
      wb_wreg_d      = 1'b0;
      wb_wd_d        = '0;
      wb_whilo_d     = 1'b0;
      wb_hilo_d      = '0;
      wb_cp0_we_d    = 1'b0;
      wb_cp0_waddr_d = '0;
      wb_cp0_wdata_d = '0;
    end else if (!bus.stall_mem) begin
      // Advancing instruction consumes any held response.
      state_d        = IDLE;
      wb_wa_d        = bus.mem_wa;
      wb_wreg_d      = bus.mem_wreg;
      wb_wd_d        = bus.mem_mreg ? load_wd : bus.mem_dreg;
      wb_whilo_d     = bus.mem_whilo;
      wb_hilo_d      = bus.mem_hilo;
      wb_cp0_we_d    = bus.mem_cp0_we;
      wb_cp0_waddr_d = bus.mem_cp0_waddr;
      wb_cp0_wdata_d = bus.mem_cp0_wdata;
    end
  end

  // State, hold buffer and WB fields
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      wb_wa_q        <= '0;
      wb_wreg_q      <= 1'b0;
      wb_wd_q        <= '0;
      wb_whilo_q     <= 1'b0;
      wb_hilo_q      <= '0;
      wb_cp0_we_q    <= 1'b0;
      wb_cp0_waddr_q <= '0;
      wb_cp0_wdata_q <= '0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      wb_wa_q        <= wb_wa_d;
      wb_wreg_q      <= wb_wreg_d;
      wb_wd_q        <= wb_wd_d;
      wb_whilo_q     <= wb_whilo_d;
      wb_hilo_q      <= wb_hilo_d;
      wb_cp0_we_q    <= wb_cp0_we_d;
      wb_cp0_waddr_q <= wb_cp0_waddr_d;
      wb_cp0_wdata_q <= wb_cp0_wdata_d;
    end
  end

  assign bus.mem_data_ok  = (state_q == HELD);
  assign bus.wb_wa        = wb_wa_q;
  assign bus.wb_wreg      = wb_wreg_q;
  assign bus.wb_wd        = wb_wd_q;
  assign bus.wb_whilo     = wb_whilo_q;
  assign bus.wb_hilo      = wb_hilo_q;
  assign bus.wb_cp0_we    = wb_cp0_we_q;
  assign bus.wb_cp0_waddr = wb_cp0_waddr_q;
  assign bus.wb_cp0_wdata = wb_cp0_wdata_q;

endmodule

// File: doc/memwb_reg.md
Name: memwb_reg

Overview:
- Pipeline register between the memory-access stage and the write-back stage.
- Captures the data-memory read response (data_ok/rdata handshake) while the load is stalled in MEM, and holds it until the pipeline advances.
- Extracts the loaded byte, halfword or word, sign- or zero-extends it, and registers the final write-back value together with the GPR, HI/LO and CP0 write controls.
- Its mem_data_ok output releases the memory stage's stall request.

Parameters:
- DATA_W, 32, data/address width
- REG_AW, 5, register-file / CP0 address width

Ports:
- cpu_clk_50M  in  1  clock
- cpu_rst_n  in  1  asynchronous active-low reset
- stall_mem  in  1  MEM stage held this cycle
- stall_wb  in  1  WB stage held this cycle
- flush  in  1  exception flush; kills the MEM-stage instruction
- mem_wa  in  REG_AW  GPR destination
- mem_wreg  in  1  GPR write enable
- mem_dreg  in  DATA_W  ALU result, or load address when mem_mreg=1
- mem_mreg  in  1  instruction is a load
- mem_dre  in  4  load byte-lane enables
- mem_sign  in  1  sign-extend load
- mem_whilo  in  1  HI/LO write enable
- mem_hilo  in  2*DATA_W  HI/LO value
- mem_cp0_we  in  1  CP0 write enable
- mem_cp0_waddr  in  REG_AW  CP0 address
- mem_cp0_wdata  in  DATA_W  CP0 data
- data_ok  in  1  one-cycle memory read/write completion pulse
- data_rdata  in  DATA_W  read data, valid with data_ok
- mem_data_ok  out  1  response held; memory stage drops dce
- wb_wa  out  REG_AW
- wb_wreg  out  1
- wb_wd  out  DATA_W  final GPR write data
- wb_whilo  out  1
- wb_hilo  out  2*DATA_W
- wb_cp0_we  out  1
- wb_cp0_waddr  out  REG_AW
- wb_cp0_wdata  out  DATA_W

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (cpu_rst_n). Reset clears every register. All outputs are 0 and the FSM goes to IDLE.
- FSM:
  - IDLE, data_ok=1 -> HELD; capture rdata into hold_q.
  - HELD -> IDLE on an advance edge (stall_mem=0) or on flush.
  - data_ok while HELD is ignored (protocol violation; hold_q is kept).
- mem_data_ok = (state==HELD). It is registered, so it rises the cycle after data_ok. Stores use the same path: rdata is captured but unused.
- Pipeline update, in priority order:
  1. flush=1: all wb_* cleared to 0; state -> IDLE.
  2. stall_mem=1 and stall_wb=0: a bubble is inserted (wb_wreg, wb_whilo and wb_cp0_we = 0; other fields may be 0).
  3. stall_mem=0: all mem_* fields registered into wb_*; state -> IDLE.
  4. Otherwise: wb_* hold.
- wb_wd on advance:
  - mem_mreg=0: mem_dreg.
  - mem_mreg=1: ext(hold_q, mem_dre, mem_sign, region).
  - A load that advances without HELD (exception-killed dce) writes ext of the stale hold_q. This is harmless because wb_wreg is expected to be cleared by flush.
- Raw word R = hold_q. local = mem_dreg[31:28] is 0x8 or 0x0, or mem_dreg[31:20] = 0xbfc.
- Extraction, local (byte-swapped storage):
  - dre 1000/0100/0010/0001: byte R[31:24]/R[23:16]/R[15:8]/R[7:0].
  - dre 1100: half {R[23:16],R[31:24]}.
  - dre 0011: half {R[7:0],R[15:8]}.
  - dre 1111: word {R[7:0],R[15:8],R[23:16],R[31:24]}.
- Extraction, non-local: byte lanes as above; half 1100 = R[31:16], 0011 = R[15:0]; word = R.
- Bytes and halves are extended to 32 bits: sign-extended when mem_sign=1, zero-extended otherwise. Any other dre pattern gives 0.
- Reset mid-wait: the FSM returns to IDLE and a late data_ok is accepted as a new capture. The system resets memory too.

Optional Feature:
- Macro LOAD_BYTE_SWAP_EN.
- Defined: the local-region byte-swap rules above apply.
- Undefined: every address uses the non-local rules, and the region compare logic is removed.

Test Plan:
- LW local: mem_dreg=0x80000010, dre=1111, data_ok with rdata=0x44332211 -> mem_data_ok=1 the next cycle; after stall_mem drops, wb_wd=0x11223344 and wb_wreg=1; state IDLE.
- LB signed: dre=0010, sign=1, rdata=0x0000F000 -> wb_wd=0xFFFFFFF0. Same with sign=0 -> 0x000000F0.
- LH non-local: mem_dreg=0x1FAF0002, dre=0011, sign=1, rdata=0x12348001 -> wb_wd=0xFFFF8001. With LOAD_BYTE_SWAP_EN undefined and a local address, same result.
- Stall: stall_mem=1, stall_wb=0 for 3 cycles -> wb_wreg=0 each cycle. stall_mem=stall_wb=1 -> wb_* unchanged.
- Flush while HELD: flush=1 -> all wb_* = 0, mem_data_ok=0 the next cycle, state IDLE.
- Async reset pulse mid-HELD -> all outputs 0 immediately, without a clock edge.
